// File: rtl/lrsc_arbiter_pkg.sv
// Shared types for the multi-hart LR/SC arbiter: configuration record,
// reservation-set op codes and the arbiter FSM states.
package lrsc_arbiter_pkg;

    typedef struct packed {
        int unsigned PA_BITS;
    } cvw_t;

    localparam cvw_t CVW_DEFAULT = '{PA_BITS: 34};

    typedef enum logic [1:0] {
        RS_LR  = 2'b00,
        RS_SC  = 2'b01,
        RS_ST  = 2'b10,
        RS_AMO = 2'b11
    } rsop_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP
    } arb_state_t;

    // Any write that reaches memory invalidates other harts' reservations on the granule.
    function automatic logic kills_others(input rsop_t op);
        return op != RS_LR;
    endfunction

endpackage

// File: rtl/lrsc_arbiter_if.sv
// Request/grant, shared memory port and completion signals between the
// harts' atomic paths, the arbiter and the shared memory interface.
interface lrsc_arbiter_if
    import lrsc_arbiter_pkg::*;
#(
    parameter int NHARTS = 2,
    parameter int AW     = 32
);

    logic [NHARTS-1:0]          ReqValid;
    logic [NHARTS-1:0][1:0]     ReqOp;
    logic [NHARTS-1:0][AW-1:0]  ReqAdr;
    logic [NHARTS-1:0]          ReqReady;

    logic                       MemValid;
    rsop_t                      MemOp;
    logic [AW-1:0]              MemAdr;
    logic                       MemReady;

    logic [NHARTS-1:0]          RespValid;
    logic                       RespSCFail;

    modport slave (
        input  ReqValid, ReqOp, ReqAdr, MemReady,
        output ReqReady, MemValid, MemOp, MemAdr, RespValid, RespSCFail
    );

    modport master (
        output ReqValid, ReqOp, ReqAdr, MemReady,
        input  ReqReady, MemValid, MemOp, MemAdr, RespValid, RespSCFail
    );

endinterface

// File: rtl/lrsc_arbiter_rrarb.sv
// Round-robin arbiter: grants the lowest-indexed requester at or after the
// pointer, wrapping to the lowest requester overall.
module lrsc_arbiter_rrarb #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant
);

    logic [N-1:0] w_mask;
    logic [N-1:0] w_hi;
    logic [N-1:0] w_sel;

    // Requesters at or above the pointer win; otherwise wrap around.
    assign w_mask  = ~((N'(1) << i_ptr) - N'(1));
    assign w_hi    = i_req & w_mask;
    assign w_sel   = (|w_hi) ? w_hi : i_req;
    assign o_grant = w_sel & (~w_sel + N'(1));

endmodule

// File: rtl/lrsc_arbiter.sv
// Serializes LR/SC/ST/AMO requests from several harts onto one memory port
// and keeps every hart's load-reserved reservation coherent.
module lrsc_arbiter
    import lrsc_arbiter_pkg::*;
#(
    parameter cvw_t P      = CVW_DEFAULT,
    parameter int   NHARTS = 2
) (
    input  logic          clk,
    input  logic          reset,
    lrsc_arbiter_if.slave bus
);

    localparam int AW = int'(P.PA_BITS) - 2;
    localparam int PW = (NHARTS > 1) ? $clog2(NHARTS) : 1;

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    logic [NHARTS-1:0] r_res_valid;
    logic [AW-1:0]     r_res_adr [NHARTS];
    logic [PW-1:0]     r_rrptr;
    logic [PW-1:0]     r_win_id;
    rsop_t             r_win_op;
    logic [AW-1:0]     r_win_adr;
    logic              r_win_fail;

    logic              w_grant_en;
    logic [NHARTS-1:0] w_req;
    logic [NHARTS-1:0] w_grant;
    logic [PW-1:0]     w_grant_id;
    logic              w_any;
    rsop_t             w_sel_op;
    logic [AW-1:0]     w_sel_adr;
    logic              w_sc_fail;
    logic              w_mem_acc;

    // Grants only leave IDLE, and never while reset is held.
    assign w_grant_en = (r_state == S_IDLE) && reset;
    assign w_req      = w_grant_en ? bus.ReqValid : '0;

    lrsc_arbiter_rrarb #(
        .N  (NHARTS),
        .PW (PW)
    ) u_rrarb (
        .i_req   (w_req),
        .i_ptr   (r_rrptr),
        .o_grant (w_grant)
    );

    always_comb begin
        w_grant_id = '0;
        for (int unsigned i = 0; i < NHARTS; i++) begin
            if (w_grant[i]) w_grant_id = PW'(i);
        end
    end

    assign w_any     = |w_grant;
    assign w_sel_op  = rsop_t'(bus.ReqOp[w_grant_id]);
    assign w_sel_adr = bus.ReqAdr[w_grant_id];
    assign w_sc_fail = (w_sel_op == RS_SC) &&
                       !(r_res_valid[w_grant_id] && (r_res_adr[w_grant_id] == w_sel_adr));
    assign w_mem_acc = (r_state == S_ISSUE) && bus.MemReady;

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next   = r_state;
        bus.ReqReady   = w_grant;
        bus.MemValid   = 1'b0;
        bus.MemOp      = r_win_op;
        bus.MemAdr     = r_win_adr;
        bus.RespValid  = '0;
        bus.RespSCFail = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) w_state_next = w_sc_fail ? S_RESP : S_ISSUE;
            end
            S_ISSUE: begin
                bus.MemValid = 1'b1;
                if (bus.MemReady) w_state_next = S_RESP;
            end
            S_RESP: begin
                bus.RespValid[r_win_id] = 1'b1;
                bus.RespSCFail          = r_win_fail;
                w_state_next            = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_res_valid <= '0;
            r_rrptr     <= '0;
            r_win_id    <= '0;
            r_win_op    <= RS_LR;
            r_win_adr   <= '0;
            r_win_fail  <= 1'b0;
            for (int unsigned j = 0; j < NHARTS; j++) r_res_adr[j] <= '0;
        end else begin
            if (w_any) begin
                r_win_id   <= w_grant_id;
                r_win_op   <= w_sel_op;
                r_win_adr  <= w_sel_adr;
                r_win_fail <= w_sc_fail;
                r_rrptr    <= (w_grant_id == PW'(NHARTS - 1)) ? '0 : w_grant_id + 1'b1;
                if (w_sc_fail) r_res_valid[w_grant_id] <= 1'b0;
            end
            // Memory acceptance is the serialization point for reservation updates.
            if (w_mem_acc) begin
                for (int unsigned j = 0; j < NHARTS; j++) begin
                    if (kills_others(r_win_op) && (PW'(j) != r_win_id) &&
                        (r_res_adr[j] == r_win_adr))
                        r_res_valid[j] <= 1'b0;
                end
                if (r_win_op == RS_LR) begin
                    r_res_valid[r_win_id] <= 1'b1;
                    r_res_adr[r_win_id]   <= r_win_adr;
                end else if (r_win_op == RS_SC) begin
                    r_res_valid[r_win_id] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/lrsc_arbiter.md
# lrsc_arbiter

Serializes LR/SC, store and AMO requests from several harts onto one shared memory port and owns every hart's load-reserved reservation. The per-hart LR/SC squash unit handles only a single hart's local reservation. This block adds the multi-hart rule: a store, AMO or successful SC to a granule clears every other hart's reservation on that granule. It sits between the per-hart LSU atomic paths and the shared L2/bus interface.

## Interface
Parameters:
- P: cvw_t configuration; uses P.PA_BITS.
- NHARTS, default 2: number of requesting harts (2–8).

Ports:
- clk  input  1  sole clock.
- reset  input  1  synchronous, active-low reset.
- ReqValid  input  NHARTS  per-hart request valid.
- ReqOp  input  NHARTS×2  per-hart op (rsop_t: LR, SC, ST, AMO).
- ReqAdr  input  NHARTS×(PA_BITS-2)  per-hart word-granule address, PA[PA_BITS-1:2].
- ReqReady  output  NHARTS  one-hot grant pulse; request accepted.
- MemValid  output  1  shared memory request valid.
- MemOp  output  2  op of issued request.
- MemAdr  output  PA_BITS-2  granule address of issued request.
- MemReady  input  1  memory accepts request.
- RespValid  output  NHARTS  one-hot completion pulse.
- RespSCFail  output  1  qualifies RespValid; 1 = SC failed (no memory write).

## Operation
- State per hart: ResValid[i] (1 bit), ResAdr[i] (PA_BITS-2).
- Shared state: a round-robin pointer RRPtr (clog2(NHARTS)) and an FSM holding a latched winner (WinId, WinOp, WinAdr, WinFail).
- FSM states:
  - IDLE: if any ReqValid, the arbiter selects the first requester at or after RRPtr and pulses ReqReady[WinId]. The FSM latches op and address and sets RRPtr ← WinId+1 (mod NHARTS).
    - Latched SC with ~(ResValid[WinId] & ResAdr[WinId]==adr): WinFail=1, next RESP.
    - Otherwise: next ISSUE.
  - ISSUE: MemValid=1 with MemOp/MemAdr from the latch, held stable until MemReady. On MemValid&MemReady, apply the reservation update, then go to RESP.
  - RESP: RespValid[WinId]=1 for one cycle, RespSCFail=WinFail, then IDLE.
- Reservation update at memory acceptance (the serialization point):
  - LR: ResValid[WinId]←1, ResAdr[WinId]←adr.
  - SC (success): ResValid[WinId]←0. For every j≠WinId with ResAdr[j]==adr, ResValid[j]←0.
  - ST/AMO: for every j≠WinId with ResAdr[j]==adr, ResValid[j]←0. The own reservation is unchanged.
- A failed SC never reaches memory. It clears ResValid[WinId] when the FSM enters RESP.
- A new LR by a hart overwrites that hart's previous reservation.
- No requester is ever granted while the FSM is out of IDLE.

## Timing
- Reset values: ReqReady=0, MemValid=0, MemOp=0, MemAdr=0, RespValid=0, RespSCFail=0, all ResValid=0, RRPtr=0, FSM=IDLE.
- Grant in cycle t. MemValid asserted from t+1. If MemReady is high in t+1, RespValid is high in t+2. Minimum issued-op latency is 2 cycles after grant.
- A failed SC gives RespValid at t+1 with no MemValid cycle.
- Back-to-back throughput: one op per 3 cycles (grant, issue, resp) when MemReady is always high.
- Simultaneous ReqValid: exactly one ReqReady. Losers must hold ReqValid/ReqOp/ReqAdr stable until granted.
- Requester fairness: a continuously requesting hart is granted within NHARTS grants.
- Reset low in any state: the next edge returns to the reset values and discards any in-flight request. Memory is required to drop an unaccepted request on the same reset.
- Address compare is a full PA_BITS-2 bit equality. No partial-granule aliasing.

## Structure
- rsop_t (LR=2'b00, SC=2'b01, ST=2'b10, AMO=2'b11) and the FSM state enum live in the cvw package.
- One sub-module, rrarb: a parameterized round-robin arbiter that takes the request vector and pointer and returns a one-hot grant. This block instantiates it once.
- Reservation registers and the FSM are flops with synchronous active-low clear.

## Test plan
- Hart0 LR 0x100, then hart0 SC 0x100 → MemValid with MemOp=SC; RespSCFail=0; ResValid[0]=0 afterwards.
- Hart0 LR 0x100, hart1 ST 0x100, hart0 SC 0x100 → the SC completes with RespSCFail=1, RespValid one cycle after grant, and no MemValid for the SC.
- Hart0 and hart1 both request in the same cycle from reset → hart0 granted first, hart1 next; RRPtr=0 after both.
- Hart0 LR 0x100, hart0 ST 0x100, hart0 SC 0x100 → SC succeeds (own store keeps the reservation).
- MemReady held low for 5 cycles in ISSUE → MemValid, MemOp and MemAdr stay stable, no RespValid, no new grant; completion 1 cycle after MemReady.
- Reset asserted low during ISSUE → next cycle MemValid=0, FSM=IDLE, all ResValid=0; a following SC fails.
